fetcher: RTL and testbench
==========================

# fetcher

Instruction fetch stage sitting directly upstream of the instruction queue (iq). It looks up the PC the iq wants next in a direct-mapped instruction cache and returns the 32-bit instruction in the same cycle on a hit. On a miss it arbitrates for the byte-wide memory controller, reads four bytes little-endian, fills the cache and then reports the hit. A ROB exception aborts any miss in flight.

## Interface
- `IndexWidth`, default 4: cache index bits; the cache has 2^IndexWidth one-instruction lines.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pc_from_iq` in 32: next PC requested by the iq.
- `is_exception_from_rob` in 1: flush; abort the miss in progress.
- `is_hit_to_iq` out 1: `instr_to_iq` is valid for `pc_from_iq` this cycle.
- `instr_to_iq` out 32: instruction; 0 when not hit.
- `is_req_to_mc` out 1: bus request to the memory controller.
- `is_grant_from_mc` in 1: bus granted; sampled at posedge while requesting.
- `is_rd_to_mc` out 1: byte read strobe.
- `addr_to_mc` out 32: byte address; 0 when `is_rd_to_mc`=0.
- `data_from_mc` in 8: read byte, valid the cycle after its address.

## Operation
- Line address fields:
  - index = `pc[IndexWidth+1:2]`; tag = `pc[31:IndexWidth+2]`.
  - `pc[1:0]` is ignored for lookup.
- Per-line state: valid bit, tag, 32-bit data, all registered.
- Hit is combinational: `is_hit_to_iq` = state IDLE && valid[index] && tag match && !`is_exception_from_rob`.
- FSM states: IDLE, REQ, READ.
- IDLE:
  - On a miss with no exception, latch `miss_pc` = `pc_from_iq`, then go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `is_req_to_mc`=1.
  - Grant sampled at posedge, then go to READ with `cnt`=0.
  - Stay in REQ while grant is low.
- READ, `cnt` 0..4, `is_req_to_mc`=1:
  - For `cnt`<4: `is_rd_to_mc`=1 and `addr_to_mc` = `miss_pc`+`cnt`, with 32-bit wrap.
  - For `cnt`≥1: capture `data_from_mc` into byte `cnt`-1 of the assembly register.
  - At the posedge ending `cnt`=4: write the line (valid=1, tag, data) and go to IDLE.
- Exception in any state:
  - At the next posedge: state IDLE, `cnt`=0, no cache write.
  - Captured bytes are discarded.
  - Cache contents are retained.
- If the iq does not accept a hit (queue full), the PC is unchanged and the hit persists. The fetcher needs no backpressure input.

## Timing
- Reset values:
  - State IDLE; all valid bits 0.
  - `is_hit_to_iq`=0, `instr_to_iq`=0, `is_req_to_mc`=0, `is_rd_to_mc`=0, `addr_to_mc`=0.
- Hit latency: 0 cycles, combinational from `pc_from_iq`. Back-to-back hits give 1 instruction per cycle.
- Miss latency with immediate grant:
  - Miss in cycle t.
  - REQ in cycle t+1.
  - READ in cycles t+2..t+6; bytes addressed in t+2..t+5 and captured in t+3..t+6.
  - Hit in cycle t+7.
- Each cycle of grant delay adds 1 cycle.
- Exception and grant in the same cycle: the exception wins and the state returns to IDLE.
- Exception on the fill edge: no write.
- Async reset mid-miss: immediate return to reset values; no partial fill.

## Configuration
- `FETCHER_ICACHE_EN` defined: the cache is as described above.
- `FETCHER_ICACHE_EN` undefined:
  - The cache is replaced by a single buffer: one valid bit, a 30-bit `pc[31:2]`, and 32-bit data.
  - Hit when valid && `pc_from_iq[31:2]` matches.
  - A fill overwrites the buffer.
  - FSM, timing and exception rules are unchanged.

## Test plan
- Reset, then `pc_from_iq`=0x0, memory bytes 0x13,0x05,0x10,0x00 at 0..3, grant tied high -> `is_req_to_mc` in cycle 1, `addr_to_mc` 0,1,2,3 in cycles 2–5, `is_hit_to_iq`=1 with `instr_to_iq`=0x00100513 in cycle 7.
- After filling 0x0 and 0x4, toggle `pc_from_iq` 0x0/0x4 every cycle -> hit every cycle, correct data, no `is_req_to_mc`.
- Fill 0x0, then request 0x40 (same index, IndexWidth=4) -> miss and refill; then request 0x0 -> miss again (conflict eviction). Without `FETCHER_ICACHE_EN`, 0x4 after 0x0 also misses.
- Assert `is_exception_from_rob` during READ `cnt`=2 with `pc_from_iq` changing to 0x100 -> IDLE next cycle, no write (0x0 still misses later), new miss on 0x100 starts the following cycle.
- Hold `is_grant_from_mc` low for 5 cycles -> `is_req_to_mc` stays 1, `is_rd_to_mc` stays 0; hit arrives 5 cycles later than the baseline.
- Deassert `rst` during READ -> all outputs 0 immediately; after release the same PC misses again.

Source files
------------

// File: rtl/fetcher.sv
// -----------------------------------------------------------------------------
// fetcher -- instruction fetch stage in front of the instruction queue (iq).
//
// The iq presents the PC it wants next. A lookup returns the 32-bit instruction
// combinationally on a hit. On a miss the fetcher requests the byte-wide memory
// controller (mc). Once it holds the bus, it reads four bytes little-endian
// from miss_pc, miss_pc+1, miss_pc+2 and miss_pc+3, fills the store and returns
// to IDLE, where the lookup then hits. A ROB exception aborts a miss in flight
// without touching the store.
//
// Build option (macro FETCHER_ICACHE_EN):
//   defined   : direct-mapped cache of 2^IndexWidth one-instruction lines,
//               index = pc[IndexWidth+1:2], tag = pc[31:IndexWidth+2].
//   undefined : a single buffer holding {valid, pc[31:2], data}.
//
// Ports:
//   clk                    in   rising-edge clock
//   rst                    in   asynchronous active-low reset
//   pc_from_iq      [31:0] in   PC requested by the iq (pc[1:0] ignored for lookup)
//   is_exception_from_rob  in   flush: abort any miss in flight
//   is_hit_to_iq           out  instr_to_iq is valid for pc_from_iq this cycle
//   instr_to_iq     [31:0] out  instruction, 0 when not a hit
//   is_req_to_mc           out  bus request, held through REQ and READ
//   is_grant_from_mc       in   bus grant, sampled at posedge while in REQ
//   is_rd_to_mc            out  byte read strobe
//   addr_to_mc      [31:0] out  byte address, 0 when is_rd_to_mc is low
//   data_from_mc     [7:0] in   read byte, valid the cycle after its address
// -----------------------------------------------------------------------------
module fetcher #(
  parameter int IndexWidth = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_from_iq,
  input  logic        is_exception_from_rob,
  output logic        is_hit_to_iq,
  output logic [31:0] instr_to_iq,
  output logic        is_req_to_mc,
  input  logic        is_grant_from_mc,
  output logic        is_rd_to_mc,
  output logic [31:0] addr_to_mc,
  input  logic [7:0]  data_from_mc
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] READ = 2'd2;

  logic [1:0]  state;
  logic [2:0]  cnt;
  logic [31:0] miss_pc;
  // Bytes 0..2 of the line being assembled. Byte 3 arrives on the fill edge
  // and goes straight into the store, so it needs no holding register.
  logic [23:0] asm_data;

  logic        lookup_hit;
  logic [31:0] lookup_data;
  logic        fill_en;
  logic [31:0] fill_data;

  logic [1:0]  unused_pc_lsb;
  assign unused_pc_lsb = pc_from_iq[1:0];

  // An exception on the last READ edge suppresses the write.
  assign fill_en   = (state == READ) && (cnt == 3'd4) && !is_exception_from_rob;
  assign fill_data = {data_from_mc, asm_data};

`ifdef FETCHER_ICACHE_EN
  localparam int TagWidth = 30 - IndexWidth;
  localparam int Lines    = 1 << IndexWidth;

  logic [IndexWidth-1:0] rd_idx;
  logic [IndexWidth-1:0] wr_idx;
  logic [TagWidth-1:0]   rd_tag;
  logic [TagWidth-1:0]   wr_tag;
  logic [Lines-1:0]      line_valid;
  logic [TagWidth-1:0]   line_tag  [Lines];
  logic [31:0]           line_data [Lines];

  assign rd_idx = pc_from_iq[IndexWidth+1:2];
  assign rd_tag = pc_from_iq[31:IndexWidth+2];
  assign wr_idx = miss_pc[IndexWidth+1:2];
  assign wr_tag = miss_pc[31:IndexWidth+2];

  assign lookup_hit  = line_valid[rd_idx] && (line_tag[rd_idx] == rd_tag);
  assign lookup_data = line_data[rd_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_valid <= '0;
    end else if (fill_en) begin
      line_valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      line_tag[wr_idx]  <= wr_tag;
      line_data[wr_idx] <= fill_data;
    end
  end
`else
  logic        buf_valid;
  logic [29:0] buf_pc;
  logic [31:0] buf_data;

  // IndexWidth has no effect on the single buffer; the slice is only named
  // so that the parameter still has a reader in this build.
  logic [IndexWidth-1:0] unused_index;
  assign unused_index = pc_from_iq[IndexWidth+1:2];

  assign lookup_hit  = buf_valid && (buf_pc == pc_from_iq[31:2]);
  assign lookup_data = buf_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
    end else if (fill_en) begin
      buf_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      buf_pc   <= miss_pc[31:2];
      buf_data <= fill_data;
    end
  end
`endif

  // Control FSM. The exception overrides every state, including a grant
  // arriving in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else if (is_exception_from_rob) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!lookup_hit) begin
            state <= REQ;
          end
        end
        REQ: begin
          if (is_grant_from_mc) begin
            state <= READ;
            cnt   <= 3'd0;
          end
        end
        READ: begin
          if (cnt == 3'd4) begin
            state <= IDLE;
            cnt   <= 3'd0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

  // Datapath registers, no reset. miss_pc may be loaded during reset or on an
  // exception cycle; it is only consumed after a clean IDLE->REQ transition.
  // Stale assembly bytes after an abort are always overwritten before the
  // next fill.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && !lookup_hit) begin
      miss_pc <= pc_from_iq;
    end
    if (state == READ) begin
      case (cnt)
        3'd1:    asm_data[7:0]   <= data_from_mc;
        3'd2:    asm_data[15:8]  <= data_from_mc;
        3'd3:    asm_data[23:16] <= data_from_mc;
        default: ;
      endcase
    end
  end

  assign is_hit_to_iq = (state == IDLE) && lookup_hit && !is_exception_from_rob;
  assign instr_to_iq  = is_hit_to_iq ? lookup_data : 32'd0;
  assign is_req_to_mc = (state == REQ) || (state == READ);
  assign is_rd_to_mc  = (state == READ) && (cnt != 3'd4);
  assign addr_to_mc   = is_rd_to_mc ? (miss_pc + {29'd0, cnt}) : 32'd0;

endmodule

// File: tb/tb_fetcher.sv
module tb_fetcher;

  localparam int IW = 4;
  localparam int NL = 1 << IW;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_from_iq = 32'd0;
  logic        is_exception_from_rob = 1'b0;
  logic        is_hit_to_iq;
  logic [31:0] instr_to_iq;
  logic        is_req_to_mc;
  logic        is_grant_from_mc = 1'b0;
  logic        is_rd_to_mc;
  logic [31:0] addr_to_mc;
  logic [7:0]  data_from_mc = 8'd0;

  always #5 clk = ~clk;

  fetcher #(.IndexWidth(IW)) dut (
    .clk(clk),
    .rst(rst),
    .pc_from_iq(pc_from_iq),
    .is_exception_from_rob(is_exception_from_rob),
    .is_hit_to_iq(is_hit_to_iq),
    .instr_to_iq(instr_to_iq),
    .is_req_to_mc(is_req_to_mc),
    .is_grant_from_mc(is_grant_from_mc),
    .is_rd_to_mc(is_rd_to_mc),
    .addr_to_mc(addr_to_mc),
    .data_from_mc(data_from_mc)
  );

  int total  = 0;
  int passed = 0;

  logic        prev_rd = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic        o_hit, o_req, o_rd;
  logic [31:0] o_instr, o_addr;

  // Reference model: a store of remembered words keyed by slot, plus a view
  // of the outstanding miss as "waiting for the bus" or "k beats into it".
  logic        m_busy;
  logic        m_granted;
  int          m_k;
  logic [31:0] m_pc;
  logic        m_v    [NL];
  logic [31:0] m_wpc  [NL];
  logic [31:0] m_word [NL];

  function automatic logic [7:0] mem(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA7;
    endcase
  endfunction

  function automatic int slot(input logic [31:0] pc);
`ifdef FETCHER_ICACHE_EN
    return int'(pc[IW+1:2]);
`else
    return (pc == 32'd0) ? 0 : 0;
`endif
  endfunction

  function automatic logic present(input logic [31:0] pc);
    int s;
    s = slot(pc);
    return m_v[s] && (m_wpc[s][31:2] == pc[31:2]);
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_granted = 1'b0;
    m_k = 0;
    m_pc = 32'd0;
    for (int i = 0; i < NL; i++) m_v[i] = 1'b0;
  endtask

  task automatic model_expect(input logic [31:0] pc, input logic exc,
                              output logic e_hit, output logic [31:0] e_instr,
                              output logic e_req, output logic e_rd,
                              output logic [31:0] e_addr);
    e_hit = 1'b0; e_instr = 32'd0; e_req = 1'b0; e_rd = 1'b0; e_addr = 32'd0;
    if (!m_busy) begin
      e_hit = present(pc) && !exc;
      if (e_hit) e_instr = m_word[slot(pc)];
    end else begin
      e_req = 1'b1;
      if (m_granted && m_k < 4) begin
        e_rd = 1'b1;
        e_addr = m_pc + 32'(m_k);
      end
    end
  endtask

  task automatic model_advance(input logic [31:0] pc, input logic exc, input logic gnt);
    int s;
    if (exc) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (!present(pc)) begin
        m_busy = 1'b1;
        m_granted = 1'b0;
        m_pc = pc;
      end
    end else if (!m_granted) begin
      if (gnt) begin
        m_granted = 1'b1;
        m_k = 0;
      end
    end else if (m_k == 4) begin
      s = slot(m_pc);
      m_v[s] = 1'b1;
      m_wpc[s] = m_pc;
      m_word[s] = {mem(m_pc + 32'd3), mem(m_pc + 32'd2), mem(m_pc + 32'd1), mem(m_pc)};
      m_busy = 1'b0;
    end else begin
      m_k++;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
  endtask

  // One clock cycle: called at a negedge, applies inputs, samples 1 time unit
  // later, compares with the model, then waits for the next negedge.
  task automatic step(input logic [31:0] pc, input logic exc, input logic gnt);
    logic e_hit, e_req, e_rd;
    logic [31:0] e_instr, e_addr;
    pc_from_iq = pc;
    is_exception_from_rob = exc;
    is_grant_from_mc = gnt;
    data_from_mc = prev_rd ? mem(prev_addr) : 8'h00;
    #1;
    o_hit = is_hit_to_iq; o_instr = instr_to_iq; o_req = is_req_to_mc;
    o_rd = is_rd_to_mc; o_addr = addr_to_mc;
    model_expect(pc, exc, e_hit, e_instr, e_req, e_rd, e_addr);
    check("hit", 32'(o_hit), 32'(e_hit));
    check("instr", o_instr, e_instr);
    check("req", 32'(o_req), 32'(e_req));
    check("rd", 32'(o_rd), 32'(e_rd));
    check("addr", o_addr, e_addr);
    prev_rd = o_rd;
    prev_addr = o_addr;
    model_advance(pc, exc, gnt);
    @(negedge clk);
  endtask

  task automatic run_until_hit(input logic [31:0] pc, output int n);
    n = 0;
    step(pc, 1'b0, 1'b1);
    while (!o_hit && n < 40) begin
      n++;
      step(pc, 1'b0, 1'b1);
    end
    check("hit_within_budget", 32'(o_hit), 32'd1);
  endtask

  task automatic async_reset_check();
    #3;
    rst = 1'b0;
    #1;
    check("rst_hit", 32'(is_hit_to_iq), 32'd0);
    check("rst_instr", instr_to_iq, 32'd0);
    check("rst_req", 32'(is_req_to_mc), 32'd0);
    check("rst_rd", 32'(is_rd_to_mc), 32'd0);
    check("rst_addr", addr_to_mc, 32'd0);
    model_reset();
    prev_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic [31:0] instr;
    logic        req;
    logic        rd;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[8];
  logic [31:0] pool[6];

  initial begin
    int n;
    logic [31:0] rpc;

    // Baseline miss on 0x0 with grant tied high.
    tbl[0] = '{32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
    tbl[1] = '{32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};
    tbl[2] = '{32'h0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0};
    tbl[3] = '{32'h0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1};
    tbl[4] = '{32'h0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h2};
    tbl[5] = '{32'h0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h3};
    tbl[6] = '{32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};
    tbl[7] = '{32'h0, 1'b1, 32'h00100513, 1'b0, 1'b0, 32'h0};

    model_reset();
    @(negedge clk);
    check("reset_hit", 32'(is_hit_to_iq), 32'd0);
    check("reset_instr", instr_to_iq, 32'd0);
    check("reset_req", 32'(is_req_to_mc), 32'd0);
    check("reset_rd", 32'(is_rd_to_mc), 32'd0);
    check("reset_addr", addr_to_mc, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].pc, 1'b0, 1'b1);
      check("tbl_hit", 32'(o_hit), 32'(tbl[i].hit));
      check("tbl_instr", o_instr, tbl[i].instr);
      check("tbl_req", 32'(o_req), 32'(tbl[i].req));
      check("tbl_rd", 32'(o_rd), 32'(tbl[i].rd));
      check("tbl_addr", o_addr, tbl[i].addr);
    end

`ifdef FETCHER_ICACHE_EN
    run_until_hit(32'h4, n);
    check("fill4_latency", 32'(n), 32'd7);
    for (int i = 0; i < 12; i++) begin
      step((i % 2 == 1) ? 32'h4 : 32'h0, 1'b0, 1'b1);
      check("toggle_hit", 32'(o_hit), 32'd1);
      check("toggle_req", 32'(o_req), 32'd0);
    end
`else
    step(32'h4, 1'b0, 1'b1);
    check("buf_miss_4", 32'(o_hit), 32'd0);
    run_until_hit(32'h4, n);
    check("buf_fill4_latency", 32'(n), 32'd6);
    step(32'h0, 1'b0, 1'b1);
    check("buf_miss_0", 32'(o_hit), 32'd0);
    run_until_hit(32'h0, n);
`endif

    // Conflict eviction: 0x40 shares the line of 0x0.
    run_until_hit(32'h40, n);
    check("conflict_latency", 32'(n), 32'd7);
    step(32'h0, 1'b0, 1'b1);
    check("conflict_miss_0", 32'(o_hit), 32'd0);
    run_until_hit(32'h0, n);
    check("refill0_latency", 32'(n), 32'd6);

    // Address wrap across 0xFFFFFFFF.
    run_until_hit(32'hFFFF_FFFE, n);
    check("wrap_latency", 32'(n), 32'd7);
    check("wrap_instr", o_instr, {8'h05, 8'h13, mem(32'hFFFF_FFFF), mem(32'hFFFF_FFFE)});

    // Exception during READ cnt=2 while the iq moves to 0x100.
    step(32'h308, 1'b0, 1'b1);
    step(32'h308, 1'b0, 1'b1);
    step(32'h308, 1'b0, 1'b1);
    step(32'h308, 1'b0, 1'b1);
    step(32'h100, 1'b1, 1'b1);
    check("exc_cnt2_addr", o_addr, 32'h30A);
    step(32'h100, 1'b0, 1'b1);
    check("exc_idle_req", 32'(o_req), 32'd0);
    check("exc_idle_hit", 32'(o_hit), 32'd0);
    step(32'h100, 1'b0, 1'b1);
    check("exc_new_req", 32'(o_req), 32'd1);
    run_until_hit(32'h100, n);
    check("exc_new_latency", 32'(n), 32'd5);
    step(32'h308, 1'b0, 1'b1);
    check("exc_no_write", 32'(o_hit), 32'd0);
    run_until_hit(32'h308, n);

    // Exception and grant in the same cycle.
    step(32'h500, 1'b0, 1'b1);
    step(32'h500, 1'b1, 1'b1);
    step(32'h500, 1'b0, 1'b1);
    check("exc_grant_req", 32'(o_req), 32'd0);
    run_until_hit(32'h500, n);
    check("exc_grant_latency", 32'(n), 32'd6);

    // Exception on the fill edge.
    for (int i = 0; i < 6; i++) step(32'h700, 1'b0, 1'b1);
    step(32'h700, 1'b1, 1'b1);
    step(32'h700, 1'b0, 1'b1);
    check("exc_fill_no_write", 32'(o_hit), 32'd0);
    run_until_hit(32'h700, n);
    check("exc_fill_latency", 32'(n), 32'd6);

    // Grant held low for five cycles.
    step(32'h540, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(32'h540, 1'b0, 1'b0);
      check("gdelay_req", 32'(o_req), 32'd1);
      check("gdelay_rd", 32'(o_rd), 32'd0);
    end
    run_until_hit(32'h540, n);
    check("gdelay_latency", 32'(1 + 5 + n), 32'd12);

    // Asynchronous reset in the middle of READ.
    for (int i = 0; i < 4; i++) step(32'h600, 1'b0, 1'b1);
    async_reset_check();
    run_until_hit(32'h600, n);
    check("post_reset_latency", 32'(n), 32'd7);

    // Randomized traffic against the model.
    pool[0] = 32'h0;  pool[1] = 32'h4;  pool[2] = 32'h40;
    pool[3] = 32'h44; pool[4] = 32'h81; pool[5] = 32'hFFFF_FFFE;
    rpc = 32'h0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 4) == 0) rpc = $urandom;
        else rpc = pool[$urandom_range(0, 5)];
      end
      step(rpc, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
